l2_dbg_inject: RTL



---
 rtl/l2_dbg_inject.sv | 137 +++++++++++++
 1 files changed

// File: rtl/l2_dbg_inject.sv
// Debug traffic injector: replays a software-loaded packet (header + payload flits)
// one or more times onto a NoC channel with valid/ready flow control.
module l2_dbg_inject #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0]    cfg_wdata,
    input  logic                     start,
    input  logic [7:0]               repeat_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     noc_valid_out,
    output logic [DATA_WIDTH-1:0]    noc_data_out,
    input  logic                     noc_ready_out,
    output logic [15:0]              pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q [DEPTH];
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         len_q, len_d;
    logic [7:0]            reps_q, reps_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  err_q, err_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;

    logic [7:0] hdr_len;
    logic       len_bad;
    logic       xfer;

    // Length is taken from the stored header, i.e. before any same-cycle write lands.
    assign hdr_len = buf_q[0][29:22];
    assign len_bad = hdr_len > 8'(DEPTH - 1);
    assign xfer    = (state_q == SEND) && noc_ready_out;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        reps_d    = reps_q;
        gap_d     = gap_q;
        err_d     = err_q;
        pkt_cnt_d = pkt_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    reps_d = (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
                    err_d  = 1'b0;
                    if (len_bad) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        len_d   = hdr_len[AW-1:0];
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q != len_q) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        reps_d    = reps_q - 8'd1;
                        idx_d     = '0;
                        if (reps_q == 8'd1) begin
                            state_d = DONE;
                        end else if (GAP_CYCLES > 0) begin
                            gap_d   = GW'(GAP_CYCLES);
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                // Loaded with GAP_CYCLES on entry, so valid stays low exactly that many cycles.
                if (gap_q <= GW'(1)) begin
                    idx_d   = '0;
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            reps_q    <= reps_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Buffer is writable only while idle, so flits stay stable for a whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else if (cfg_we && (state_q == IDLE)) begin
            buf_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign busy          = (state_q == SEND) || (state_q == GAP);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign noc_valid_out = (state_q == SEND);
    assign noc_data_out  = (state_q == SEND) ? buf_q[idx_q] : '0;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
